fir_sample_sequencer: RTL

Upstream-facing driver for the time-multiplexed FIR filter core. Buffers incoming samples in a small FIFO and issues them one at a time to the filter's `iv_din`/`i_din_valid` input. Issues only when the filter is idle and the result register is free. Captures each `o_dout_valid` result into a valid/ready output register for the downstream consumer, and flags timeouts and spurious results.

---
 rtl/fir_pkg.sv | 21 ++
 rtl/fir_sample_fifo.sv | 58 +++++
 rtl/fir_sample_sequencer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR sample sequencer: FSM encodings and
// width derivations for the input FIFO and the result-timeout counter.
package fir_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10
  } seq_state_e;

  // Pointer width for a power-of-two FIFO; never narrower than one bit.
  function automatic int fifo_addr_w(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

  // Counter must hold values up to cycles-1.
  function automatic int tmo_cnt_w(input int cycles);
    return (cycles > 2) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/fir_sample_fifo.sv
// Synchronous power-of-two FIFO with fill count; all state freezes while i_en is low.
module fir_sample_fifo
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH = 24,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_en,
  input  logic                        i_push,
  input  logic [DATA_WIDTH-1:0]       iv_din,
  input  logic                        i_pop,
  output logic [DATA_WIDTH-1:0]       ov_dout,
  output logic                        o_full,
  output logic                        o_empty,
  output logic [$clog2(FIFO_DEPTH):0] ov_fill
);

  localparam int AW = fifo_addr_w(FIFO_DEPTH);
  localparam logic [AW:0] FULL_LVL = FIFO_DEPTH[AW:0];

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [AW:0]           r_fill;
  logic                  w_do_push;
  logic                  w_do_pop;

  assign o_full    = (r_fill == FULL_LVL);
  assign o_empty   = (r_fill == '0);
  assign w_do_push = i_en && i_push && !o_full;
  assign w_do_pop  = i_en && i_pop && !o_empty;
  assign ov_dout   = r_mem[r_rd_ptr];
  assign ov_fill   = r_fill;

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_fill <= r_fill + 1'b1;
        2'b01:   r_fill <= r_fill - 1'b1;
        default: r_fill <= r_fill;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= iv_din;
  end

endmodule

// File: rtl/fir_sample_sequencer.sv
// Feeds buffered samples one at a time to the time-multiplexed FIR core and
// captures each result into a valid/ready register, flagging timeouts and stray strobes.
module fir_sample_sequencer
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH     = 24,
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_en,
  input  logic [DATA_WIDTH-1:0]       iv_s_data,
  input  logic                        i_s_valid,
  output logic                        o_s_ready,
  output logic [DATA_WIDTH-1:0]       ov_fir_din,
  output logic                        o_fir_din_valid,
  input  logic                        i_fir_ready,
  input  logic [DATA_WIDTH-1:0]       iv_fir_dout,
  input  logic                        i_fir_dout_valid,
  output logic [DATA_WIDTH-1:0]       ov_m_data,
  output logic                        o_m_valid,
  input  logic                        i_m_ready,
  output logic [$clog2(FIFO_DEPTH):0] ov_fill,
  output logic                        o_timeout,
  output logic                        o_spurious
);

  localparam int CW    = tmo_cnt_w(TIMEOUT_CYCLES);
  localparam int TLAST = TIMEOUT_CYCLES - 2;
  // Expiry is taken on the edge that would advance the counter to TIMEOUT_CYCLES-1.
  localparam logic [CW-1:0] CNT_LAST = TLAST[CW-1:0];

  seq_state_e            r_state;
  seq_state_e            w_state_nxt;
  logic [CW-1:0]         r_cnt;
  logic [CW-1:0]         w_cnt_nxt;
  logic                  r_live;
  logic [DATA_WIDTH-1:0] r_fir_din;
  logic [DATA_WIDTH-1:0] r_m_data;
  logic                  r_m_valid;
  logic                  r_timeout;
  logic                  r_spurious;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic [DATA_WIDTH-1:0] w_head;
  logic                  w_issue_ok;
  logic                  w_load_din;
  logic                  w_load_res;
  logic                  w_tmo_set;
  logic                  w_spur_set;

  // r_live keeps o_s_ready low until the first enabled edge after reset.
  assign o_s_ready       = r_live && !w_full && i_en;
  assign w_push          = i_s_valid && o_s_ready;
  assign w_pop           = (r_state == ST_ISSUE);
  assign w_issue_ok      = !w_empty && i_fir_ready && (!r_m_valid || i_m_ready);
  assign o_fir_din_valid = (r_state == ST_ISSUE) && i_en;
  assign ov_fir_din      = r_fir_din;
  assign ov_m_data       = r_m_data;
  assign o_m_valid       = r_m_valid;
  assign o_timeout       = r_timeout;
  assign o_spurious      = r_spurious;

  fir_sample_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (i_en),
    .i_push  (w_push),
    .iv_din  (iv_s_data),
    .i_pop   (w_pop),
    .ov_dout (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .ov_fill (ov_fill)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_load_din  = 1'b0;
    w_load_res  = 1'b0;
    w_tmo_set   = 1'b0;
    w_spur_set  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_spur_set = i_fir_dout_valid;
        if (w_issue_ok) begin
          w_state_nxt = ST_ISSUE;
          w_load_din  = 1'b1;
        end
      end
      ST_ISSUE: begin
        w_spur_set  = i_fir_dout_valid;
        w_cnt_nxt   = '0;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_fir_dout_valid) begin
          w_load_res  = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_tmo_set   = 1'b1;
          w_cnt_nxt   = r_cnt + 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_live     <= 1'b0;
      r_fir_din  <= '0;
      r_m_data   <= '0;
      r_m_valid  <= 1'b0;
      r_timeout  <= 1'b0;
      r_spurious <= 1'b0;
    end else if (i_en) begin
      r_live  <= 1'b1;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_load_din) r_fir_din <= w_head;
      // A reload wins over a same-cycle downstream accept.
      if (w_load_res) begin
        r_m_data  <= iv_fir_dout;
        r_m_valid <= 1'b1;
      end else if (r_m_valid && i_m_ready) begin
        r_m_valid <= 1'b0;
      end
      if (w_tmo_set)  r_timeout  <= 1'b1;
      if (w_spur_set) r_spurious <= 1'b1;
    end
  end

endmodule
